phase_cal_ctrl: RTL
===================

PHASE_CAL_CTRL -- requirements
Module: phase_cal_ctrl

Interface
REQ-001 Parameter NUM_BITS, default 8: ADC sample width, two's complement.
REQ-002 Parameter WORD_W, default 16: phase DAC word width.
REQ-003 Parameter AVGS, default 1: samples averaged per point; power of two, 1..256.
REQ-004 Parameter SWEEP_DIST, default 5: points per sweep, at least 1.
REQ-005 Parameter SWEEP_STEP, default 5: word increment between points.
REQ-006 Parameter TOL, default 10: lock tolerance on |avg-target|.
REQ-007 Parameter SETTLE, default 16: settle cycles after each word change, at least 1.
REQ-008 Parameter MAX_SWEEPS, default 8: sweeps allowed before failure.
REQ-009 Parameter TIMEOUT, default 1024: ADC watchdog cycles.
REQ-010 Clock and reset: one clock; reset is synchronous and active-high.
REQ-011 Port clk, input, 1: sole clock.
REQ-012 Port rst, input, 1: synchronous active-high reset.
REQ-013 Port start, input, 1: single-cycle calibration request.
REQ-014 Port start_word, input, WORD_W: first phase word, sampled on accepted start.
REQ-015 Port target, input, NUM_BITS signed: desired ADC value, sampled on accepted start.
REQ-016 Port adc_valid, input, 1: ADC sample strobe.
REQ-017 Port adc_data, input, NUM_BITS signed: ADC sample.
REQ-018 Port phase_word, output, WORD_W: word driven to the phi_LO shift register.
REQ-019 Port phase_word_valid, output, 1: one-cycle pulse whenever phase_word changes.
REQ-020 Port busy, output, 1: high outside IDLE.
REQ-021 Port done, output, 1: one-cycle completion pulse.
REQ-022 Port locked, output, 1: last run locked; held until next accepted start.
REQ-023 Port fail, output, 1: last run failed; held until next accepted start.
REQ-024 Port timeout, output, 1: last failure caused by the watchdog; held until next accepted start.

Function
REQ-025 States are IDLE, SET, SETTLE, ACCUM, EVAL and FINISH.
REQ-026 In IDLE, start is accepted; on the next cycle the block is in SET and phase_word equals start_word.
REQ-027 In SET, the block pulses phase_word_valid and goes to SETTLE.
REQ-028 In SETTLE, the block counts exactly SETTLE cycles, then goes to ACCUM.
REQ-029 In ACCUM, the block sums AVGS samples on adc_valid cycles into a signed register of NUM_BITS+log2(AVGS) bits, then goes to EVAL.
REQ-030 adc_valid outside ACCUM is ignored.
REQ-031 EVAL takes one cycle: avg is the sum arithmetically shifted right by log2(AVGS); err is |avg-target| computed at NUM_BITS+1 bits, no saturation.
REQ-032 If err <= TOL, the block goes to FINISH with locked=1 and phase_word unchanged.
REQ-033 If err < best_err, the block records best_err and best_word; ties keep the earlier word.
REQ-034 If no lock and the point count < SWEEP_DIST, phase_word += SWEEP_STEP (modulo 2^WORD_W) and the block goes to SET.
REQ-035 At the end of a sweep, the sweep count increments and the next sweep continues from phase_word + SWEEP_STEP with modulo wrap.
REQ-036 When the sweep count reaches MAX_SWEEPS: phase_word = best_word, one phase_word_valid pulse, fail=1, then FINISH.
REQ-037 FINISH pulses done for one cycle and returns to IDLE.
REQ-038 start while busy is ignored.
REQ-039 start and rst in the same cycle: rst wins.

Reset
REQ-040 rst returns the block to IDLE and clears all counters and accumulators, including mid-run.
REQ-041 Reset values: phase_word=0; phase_word_valid, busy, done, locked, fail and timeout all 0; best_err all ones.

Configuration
REQ-042 With PHASE_CAL_TIMEOUT_EN defined: more than TIMEOUT cycles in ACCUM without adc_valid sets fail=1 and timeout=1, applies best_word (start_word if no point has been evaluated), pulses phase_word_valid and goes to FINISH.
REQ-043 Without PHASE_CAL_TIMEOUT_EN, ACCUM waits indefinitely and timeout is tied to 0.

Structure
REQ-044 The state typedef phase_cal_state_t shall live in package ising_config.
REQ-045 Package ising_config shall hold the defaults phase_cal_avgs, phase_sweep_dist, phase_sweep_step and phase_cal_tol, which this block's parameters use.
REQ-046 The averager shall be a sub-module, phase_cal_accum (clear, valid, data -> sum, count_done).

Verification
REQ-047 start_word=100, target=0, AVGS=1, TOL=10, ADC returns 3 -> one phase_word_valid at word 100; locked=1 and done after 1+SETTLE+1+1+1 cycles plus ADC delay.
REQ-048 ADC errors 50,40,5 at words 100,105,110 -> locked at phase_word=110 after three valid pulses.
REQ-049 ADC never within TOL, SWEEP_DIST=5, MAX_SWEEPS=2, minimum err at word 115 -> 10 points evaluated, final phase_word=115, fail=1, locked=0.
REQ-050 start_word=16'hFFFE, SWEEP_STEP=5 -> second point phase_word=3.
REQ-051 AVGS=4, samples -128,-128,-128,-127 with target -128 -> avg=-128 and lock; rst asserted in SETTLE of a second run -> all outputs at reset values the next cycle.
REQ-052 With PHASE_CAL_TIMEOUT_EN, TIMEOUT=1024 and adc_valid held low -> fail=1, timeout=1 and done TIMEOUT+1 cycles after ACCUM entry.

Source files
------------

// File: rtl/ising_config_pkg.sv
// Shared configuration for the Ising-machine control blocks: phase calibration
// state encoding and the default averaging/sweep/tolerance settings.
package ising_config;

  typedef enum logic [2:0] {
    PC_IDLE   = 3'd0,
    PC_SET    = 3'd1,
    PC_SETTLE = 3'd2,
    PC_ACCUM  = 3'd3,
    PC_EVAL   = 3'd4,
    PC_FINISH = 3'd5
  } phase_cal_state_t;

  localparam int phase_cal_avgs   = 1;
  localparam int phase_sweep_dist = 5;
  localparam int phase_sweep_step = 5;
  localparam int phase_cal_tol    = 10;

  // Width of a counter that must hold values 0..max_val (never less than 1 bit).
  function automatic int ctr_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/phase_cal_accum.sv
// Sample averager front end: sums AVGS signed samples; count_done flags the
// valid strobe that completes the set so the caller can leave without a bubble.
module phase_cal_accum
  import ising_config::*;
#(
  parameter int NUM_BITS = 8,
  parameter int AVGS     = phase_cal_avgs
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     clear,
  input  logic                                     valid,
  input  logic signed [NUM_BITS-1:0]               data,
  output logic signed [NUM_BITS+$clog2(AVGS)-1:0]  sum,
  output logic                                     count_done
);

  localparam int SUM_W = NUM_BITS + $clog2(AVGS);
  localparam int CNT_W = ctr_w(AVGS);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum   <= '0;
      count <= '0;
    end else if (valid) begin
      sum   <= sum + SUM_W'(data);
      count <= count + CNT_W'(1);
    end
  end

  assign count_done = valid && (count == CNT_W'(AVGS - 1));

endmodule

// File: rtl/phase_cal_ctrl.sv
// Phase calibration controller: sweeps the phi_LO phase word until the averaged
// ADC reading is within TOL of target. Optional ADC watchdog: PHASE_CAL_TIMEOUT_EN.
module phase_cal_ctrl
  import ising_config::*;
#(
  parameter int NUM_BITS   = 8,
  parameter int WORD_W     = 16,
  parameter int AVGS       = phase_cal_avgs,
  parameter int SWEEP_DIST = phase_sweep_dist,
  parameter int SWEEP_STEP = phase_sweep_step,
  parameter int TOL        = phase_cal_tol,
  parameter int SETTLE     = 16,
  parameter int MAX_SWEEPS = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WORD_W-1:0]          start_word,
  input  logic signed [NUM_BITS-1:0] target,
  input  logic                       adc_valid,
  input  logic signed [NUM_BITS-1:0] adc_data,
  output logic [WORD_W-1:0]          phase_word,
  output logic                       phase_word_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       locked,
  output logic                       fail,
  output logic                       timeout,
  output phase_cal_state_t           dbg_state
);

  localparam int SHIFT = $clog2(AVGS);
  localparam int SUM_W = NUM_BITS + SHIFT;
  localparam int ERR_W = NUM_BITS + 1;
  localparam int SET_W = ctr_w(SETTLE);
  localparam int PT_W  = ctr_w(SWEEP_DIST);
  localparam int SW_W  = ctr_w(MAX_SWEEPS);

  phase_cal_state_t state, next_state;

  logic [SET_W-1:0]           settle_cnt;
  logic [PT_W-1:0]            point_cnt;
  logic [SW_W-1:0]            sweep_cnt;
  logic signed [NUM_BITS-1:0] target_q;
  logic [WORD_W-1:0]          best_word;
  logic [ERR_W-1:0]           best_err;
  logic signed [SUM_W-1:0]    sum;
  logic                       count_done;
  logic signed [NUM_BITS-1:0] avg;
  logic signed [ERR_W-1:0]    diff;
  logic [ERR_W-1:0]           err;
  logic                       settle_last, lock_hit, better, sweep_end, sweeps_out;
  logic                       wd_expired;
  logic [WORD_W-1:0]          cand_word, step_word;

  phase_cal_accum #(
    .NUM_BITS (NUM_BITS),
    .AVGS     (AVGS)
  ) u_accum (
    .clk        (clk),
    .rst        (rst),
    .clear      (state != PC_ACCUM),
    .valid      (adc_valid && (state == PC_ACCUM)),
    .data       (adc_data),
    .sum        (sum),
    .count_done (count_done)
  );

  // Error is taken one bit wider than the samples so |avg-target| never wraps.
  assign avg         = NUM_BITS'(sum >>> SHIFT);
  assign diff        = ERR_W'(avg) - ERR_W'(target_q);
  assign err         = diff[ERR_W-1] ? ERR_W'(-diff) : ERR_W'(diff);
  assign lock_hit    = int'(err) <= TOL;
  assign better      = err < best_err;
  assign cand_word   = better ? phase_word : best_word;
  assign step_word   = phase_word + WORD_W'(SWEEP_STEP);
  assign settle_last = settle_cnt == SET_W'(SETTLE - 1);
  assign sweep_end   = point_cnt == PT_W'(SWEEP_DIST - 1);
  assign sweeps_out  = sweep_cnt == SW_W'(MAX_SWEEPS - 1);

`ifdef PHASE_CAL_TIMEOUT_EN
  localparam int WD_W = ctr_w(TIMEOUT);
  logic [WD_W-1:0] wd_cnt;

  // Counts ACCUM cycles since entry or since the last sample strobe.
  always_ff @(posedge clk) begin
    if (rst || (state != PC_ACCUM) || adc_valid) wd_cnt <= '0;
    else                                         wd_cnt <= wd_cnt + WD_W'(1);
  end

  assign wd_expired = (state == PC_ACCUM) && !adc_valid && (wd_cnt == WD_W'(TIMEOUT));
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= PC_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      PC_IDLE:   if (start) next_state = PC_SET;
      PC_SET:    next_state = PC_SETTLE;
      PC_SETTLE: if (settle_last) next_state = PC_ACCUM;
      PC_ACCUM: begin
        if (count_done)      next_state = PC_EVAL;
        else if (wd_expired) next_state = PC_FINISH;
      end
      PC_EVAL: begin
        if (lock_hit || (sweep_end && sweeps_out)) next_state = PC_FINISH;
        else                                       next_state = PC_SET;
      end
      PC_FINISH: next_state = PC_IDLE;
      default:   next_state = PC_IDLE;
    endcase
  end

  // A failing run re-applies best_word on entry to FINISH, hence the second pulse source.
  always_comb begin
    busy             = state != PC_IDLE;
    done             = state == PC_FINISH;
    phase_word_valid = (state == PC_SET) || ((state == PC_FINISH) && fail);
    dbg_state        = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_word <= '0;
      target_q   <= '0;
      best_word  <= '0;
      best_err   <= '1;
      settle_cnt <= '0;
      point_cnt  <= '0;
      sweep_cnt  <= '0;
      locked     <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      case (state)
        PC_IDLE: begin
          if (start) begin
            phase_word <= start_word;
            target_q   <= target;
            best_word  <= start_word;
            best_err   <= '1;
            settle_cnt <= '0;
            point_cnt  <= '0;
            sweep_cnt  <= '0;
            locked     <= 1'b0;
            fail       <= 1'b0;
            timeout    <= 1'b0;
          end
        end
        PC_SETTLE: settle_cnt <= settle_last ? '0 : settle_cnt + SET_W'(1);
        PC_ACCUM: begin
          if (wd_expired) begin
            fail       <= 1'b1;
            timeout    <= 1'b1;
            phase_word <= best_word;
          end
        end
        PC_EVAL: begin
          if (better) begin
            best_err  <= err;
            best_word <= phase_word;
          end
          if (lock_hit) begin
            locked <= 1'b1;
          end else if (sweep_end) begin
            point_cnt <= '0;
            sweep_cnt <= sweep_cnt + SW_W'(1);
            if (sweeps_out) begin
              phase_word <= cand_word;
              fail       <= 1'b1;
            end else begin
              phase_word <= step_word;
            end
          end else begin
            point_cnt  <= point_cnt + PT_W'(1);
            phase_word <= step_word;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
